// File: rtl/butterfly_serial_host.sv
// butterfly_serial_host: serializes one butterfly operation onto the tile's pin protocol
// and deserializes the tile's 49-bit result frame into a parallel word.
module butterfly_serial_host #(
   parameter int LATENCY = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_mode,
   input  logic [23:0] req_aj,
   input  logic [23:0] req_ajlen,
   input  logic [23:0] req_zeta,
   output logic        res_valid,
   input  logic        res_ready,
   output logic        res_valido,
   output logic [23:0] res_bj,
   output logic [23:0] res_bjlen,
   output logic        busy,
   output logic        pin_shift_en,
   output logic        pin_data,
   output logic        pin_load_en,
   output logic        pin_load_out,
   input  logic        pin_rx
);
   typedef enum logic [2:0] {IDLE, SHIFT_IN, LOAD, WAIT, CAPTURE, SHIFT_OUT, DONE} state_t;
   localparam logic [7:0] LAST_WAIT = 8'(LATENCY > 0 ? LATENCY - 1 : 0);
   state_t      r_state;
   logic [75:0] r_sr;
   logic [48:0] r_rx;
   logic [7:0]  r_cnt;
   logic [75:0] w_frame;
   assign w_frame    = {req_mode, 1'b1, req_aj, req_ajlen, req_zeta};
   assign req_ready  = r_state == IDLE;
   assign busy       = r_state != IDLE;
   assign res_valid  = r_state == DONE;
   assign res_valido = r_rx[48];
   assign res_bj     = r_rx[47:24];
   assign res_bjlen  = r_rx[23:0];
   // pins are registered one state ahead so each pin level lines up with the state it belongs to
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_sr         <= '0;
         r_rx         <= '0;
         r_cnt        <= '0;
         pin_shift_en <= 1'b0;
         pin_data     <= 1'b0;
         pin_load_en  <= 1'b0;
         pin_load_out <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (req_valid) begin
               r_state      <= SHIFT_IN;
               r_sr         <= {w_frame[74:0], 1'b0};
               r_cnt        <= '0;
               pin_shift_en <= 1'b1;
               pin_data     <= w_frame[75];
            end
            SHIFT_IN: begin
               r_cnt <= r_cnt + 8'd1;
               if (r_cnt == 8'd75) begin
                  r_state      <= LOAD;
                  pin_shift_en <= 1'b0;
                  pin_data     <= 1'b0;
                  pin_load_en  <= 1'b1;
               end else begin
                  pin_data <= r_sr[75];
                  r_sr     <= {r_sr[74:0], 1'b0};
               end
            end
            LOAD: begin
               pin_load_en <= 1'b0;
               r_cnt       <= '0;
               if (LATENCY == 0) begin
                  r_state      <= CAPTURE;
                  pin_load_out <= 1'b1;
               end else begin
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               r_cnt <= r_cnt + 8'd1;
               if (r_cnt == LAST_WAIT) begin
                  r_state      <= CAPTURE;
                  pin_load_out <= 1'b1;
               end
            end
            CAPTURE: begin
               r_state      <= SHIFT_OUT;
               r_cnt        <= '0;
               pin_load_out <= 1'b0;
               pin_shift_en <= 1'b1;
            end
            SHIFT_OUT: begin
               r_rx  <= {r_rx[47:0], pin_rx};
               r_cnt <= r_cnt + 8'd1;
               if (r_cnt == 8'd48) begin
                  r_state      <= DONE;
                  pin_shift_en <= 1'b0;
               end
            end
            DONE: if (res_ready) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
